// File: rtl/instruction_fetch_pkg.sv
// Shared instruction/defines package for the fetch slice.
// Holds the fetched-instruction record handed to the decoder, the branch tag
// width, the BEQ opcode constant, the fetch FSM encoding and a small opcode
// helper used when branch tagging is compiled in (macro IFETCH_BRANCH_TAG_EN).
package instruction_fetch_pkg;

    localparam int BRANCH_TAG_W = 2;

    localparam logic [5:0] OP_BEQ = 6'b000100;

    typedef struct packed {
        logic [31:0]             instruction;
        logic [BRANCH_TAG_W-1:0] branch_tag;
        logic                    macroop_start;
        logic                    macroop_end;
    } fetched_instruction;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,   // no request outstanding
        FETCH_WAIT = 2'd1,   // request outstanding, response will be kept
        FETCH_DROP = 2'd2    // request outstanding, response will be discarded
    } fetch_state_e;

    // True when the word carries the BEQ opcode in bits [31:26].
    function automatic logic is_branch(input logic [31:0] instr);
        return (instr[31:26] == OP_BEQ);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Fetch output queue: a DEPTH-entry circular buffer of fetched_instruction
// records with push, pop and a flush that empties it in one cycle.
// Ports:
//   clk, rst       - clock, synchronous active-high reset
//   push/push_data - write one record (ignored when full unless popping)
//   pop            - retire the head record (ignored when empty)
//   flush          - discard all contents; wins over push and pop
//   count          - current occupancy (0..DEPTH)
//   head           - record at the read pointer, stable until popped
module fetch_fifo
    import instruction_fetch_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  fetched_instruction push_data,
    input  logic               pop,
    input  logic               flush,
    output logic [CNT_W-1:0]   count,
    output fetched_instruction head
);

    fetched_instruction mem_q [DEPTH];
    fetched_instruction mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               do_push_s, do_pop_s;

    // Next pointer, occupancy and storage contents.
    always_comb begin
        do_pop_s  = pop && (count_q != '0);
        do_push_s = push && ((count_q != CNT_W'(DEPTH)) || do_pop_s);
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push_s) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            count_d = count_q + CNT_W'(do_push_s) - CNT_W'(do_pop_s);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are only meaningful below count, so no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch front end: issues word-aligned fetch requests with at most
// one outstanding, queues returned words for the decoder and handles
// redirects (flush + restart).
// Optional feature: define IFETCH_BRANCH_TAG_EN to make the branch tag count
// BEQ words and to load it from redirect_tag; otherwise the tag is always 0.
// Ports:
//   clk, rst                          - clock, synchronous active-high reset
//   imem_req_valid/ready/addr         - fetch request channel
//   imem_resp_valid/data              - fetch response (one per request)
//   redirect_valid/pc/tag             - flush queue and restart fetch
//   out_valid/out_ready/out_instr     - queue head toward the decoder
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          FETCH_DEPTH  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic                    imem_req_valid,
    input  logic                    imem_req_ready,
    output logic [31:0]             imem_req_addr,
    input  logic                    imem_resp_valid,
    input  logic [31:0]             imem_resp_data,
    input  logic                    redirect_valid,
    input  logic [31:0]             redirect_pc,
    input  logic [BRANCH_TAG_W-1:0] redirect_tag,
    output logic                    out_valid,
    input  logic                    out_ready,
    output fetched_instruction      out_instr
);

    localparam int              CNT_W   = $clog2(FETCH_DEPTH) + 1;
    localparam logic [CNT_W:0]  DEPTH_L = (CNT_W + 1)'(FETCH_DEPTH);

    fetch_state_e            state_q, state_d;
    logic [31:0]             pc_q, pc_d;
    logic [BRANCH_TAG_W-1:0] tag_q, tag_d;
    logic [CNT_W-1:0]        q_count_s;
    logic [CNT_W:0]          inflight_s;
    logic                    outstanding_s, room_s, push_s, pop_s, req_fire_s;
    logic                    still_out_s;
    fetched_instruction      push_data_s, head_s;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state. A redirect turns any request still in flight after
    // this cycle into a dropped one; a response retires the in-flight one.
    always_comb begin
        still_out_s = (state_q != FETCH_IDLE) && !imem_resp_valid;
        if (req_fire_s) begin
            state_d = redirect_valid ? FETCH_DROP : FETCH_WAIT;
        end else if (still_out_s) begin
            state_d = redirect_valid ? FETCH_DROP : state_q;
        end else begin
            state_d = FETCH_IDLE;
        end
    end

    // FSM outputs: request and queue push. In FETCH_WAIT a new request may
    // only go out in the cycle the current one returns, counting it as still
    // occupying a slot (it becomes a queue entry this cycle).
    always_comb begin
        outstanding_s  = (state_q != FETCH_IDLE);
        inflight_s     = {1'b0, q_count_s} + (CNT_W + 1)'(outstanding_s);
        room_s         = (inflight_s < DEPTH_L);
        imem_req_valid = 1'b0;
        push_s         = 1'b0;
        case (state_q)
            FETCH_IDLE: begin
                imem_req_valid = room_s;
            end
            FETCH_WAIT: begin
                imem_req_valid = room_s && imem_resp_valid;
                push_s         = imem_resp_valid;
            end
            FETCH_DROP: begin
                imem_req_valid = 1'b0;
            end
            default: begin
                imem_req_valid = 1'b0;
            end
        endcase
        if (rst || redirect_valid) begin
            imem_req_valid = 1'b0;
            push_s         = 1'b0;
        end else begin
            push_s = push_s;
        end
    end

    assign imem_req_addr = pc_q;
    assign req_fire_s    = imem_req_valid && imem_req_ready;
    assign pop_s         = out_valid && out_ready && !redirect_valid;

    // Fetch PC: redirect wins, otherwise step one word per accepted request.
    always_comb begin
        if (redirect_valid) begin
            pc_d = redirect_pc;
        end else if (req_fire_s) begin
            pc_d = pc_q + 32'd4;
        end else begin
            pc_d = pc_q;
        end
    end

    // Branch tag for the next pushed word.
    always_comb begin
`ifdef IFETCH_BRANCH_TAG_EN
        if (redirect_valid) begin
            tag_d = redirect_tag;
        end else if (push_s && is_branch(imem_resp_data)) begin
            tag_d = tag_q + BRANCH_TAG_W'(1);
        end else begin
            tag_d = tag_q;
        end
`else
        tag_d = redirect_tag & {BRANCH_TAG_W{1'b0}};
`endif
    end

    // PC and tag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q  <= RESET_VECTOR;
            tag_q <= '0;
        end else begin
            pc_q  <= pc_d;
            tag_q <= tag_d;
        end
    end

    assign push_data_s = '{instruction:   imem_resp_data,
                           branch_tag:    tag_q,
                           macroop_start: 1'b1,
                           macroop_end:   1'b1};

    fetch_fifo #(
        .DEPTH (FETCH_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .push_data (push_data_s),
        .pop       (pop_s),
        .flush     (redirect_valid),
        .count     (q_count_s),
        .head      (head_s)
    );

    assign out_valid = (q_count_s != '0);
    assign out_instr = head_s;

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;
    import instruction_fetch_pkg::*;

    localparam logic [31:0] RV = 32'h0000_0000;
`ifdef IFETCH_BRANCH_TAG_EN
    localparam logic [31:0] EXP_TAG_AFTER_BEQ = 32'd1;
    localparam logic [31:0] EXP_TAG_MAX       = 32'((1 << BRANCH_TAG_W) - 1);
`else
    localparam logic [31:0] EXP_TAG_AFTER_BEQ = 32'd0;
    localparam logic [31:0] EXP_TAG_MAX       = 32'd0;
`endif

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    imem_req_valid;
    logic                    imem_req_ready;
    logic [31:0]             imem_req_addr;
    logic                    imem_resp_valid;
    logic [31:0]             imem_resp_data;
    logic                    redirect_valid;
    logic [31:0]             redirect_pc;
    logic [BRANCH_TAG_W-1:0] redirect_tag;
    logic                    out_valid;
    logic                    out_ready;
    fetched_instruction      out_instr;

    int checks   = 0;
    int failures = 0;

    logic        pend      = 1'b0;
    logic [31:0] pend_addr = 32'h0;
    logic        hold_resp;
    logic [31:0] got [$];

    always #5 clk = ~clk;

    instruction_fetch #(
        .RESET_VECTOR (RV),
        .FETCH_DEPTH  (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .redirect_tag    (redirect_tag),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_instr       (out_instr)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0200: mem_word = 32'h1040_0002;   // beq
            32'h0000_0204: mem_word = 32'h2401_0001;   // addiu
            32'h0000_0300: mem_word = 32'h1040_0003;   // beq
            default:       mem_word = 32'hE000_0000 | a;
        endcase
    endfunction

    // Instruction memory: answers one cycle after a handshake unless held.
    assign imem_resp_valid = pend && !hold_resp;
    assign imem_resp_data  = mem_word(pend_addr);

    always @(posedge clk) begin
        if (rst) begin
            pend <= 1'b0;
        end else begin
            if (imem_resp_valid) pend <= 1'b0;
            if (imem_req_valid && imem_req_ready) begin
                pend      <= 1'b1;
                pend_addr <= imem_req_addr;
            end
        end
    end

    // Decoder side: record every accepted word.
    always @(posedge clk) begin
        if (!rst && !redirect_valid && out_valid && out_ready)
            got.push_back(out_instr.instruction);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_tag   = '0;
        hold_resp      = 1'b0;
        tick();
        tick();
        got.delete();
        rst = 1'b0;
    endtask

    initial begin
        rst            = 1'b1;
        imem_req_ready = 1'b1;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        redirect_tag   = '0;
        hold_resp      = 1'b0;
        tick();
        tick();
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);

        // Streaming fetch, memory always ready, 1-cycle response.
        out_ready = 1'b1;
        rst       = 1'b0;
        #1;
        check("first_req_valid", 32'(imem_req_valid), 32'd1);
        check("first_req_addr", imem_req_addr, RV);
        tick();
        check("req_valid_a", 32'(imem_req_valid), 32'd1);
        check("req_addr_4", imem_req_addr, 32'h4);
        check("latency_out_valid", 32'(out_valid), 32'd0);
        tick();
        check("req_addr_8", imem_req_addr, 32'h8);
        check("head0_valid", 32'(out_valid), 32'd1);
        check("head0_instr", out_instr.instruction, mem_word(32'h0));
        check("head0_macroop", 32'({out_instr.macroop_start, out_instr.macroop_end}), 32'd3);
        check("head0_tag", 32'(out_instr.branch_tag), 32'd0);
        tick();
        check("head1_instr", out_instr.instruction, mem_word(32'h4));
        check("req_addr_c", imem_req_addr, 32'hC);

        // Decoder stalls: queue fills to depth, requests stop.
        out_ready = 1'b0;
        repeat (5) tick();
        check("full_req_valid", 32'(imem_req_valid), 32'd0);
        check("full_out_valid", 32'(out_valid), 32'd1);
        check("full_head_stable", out_instr.instruction, mem_word(32'h4));
        out_ready = 1'b1;
        repeat (10) tick();
        check("drain_size_ge6", 32'(got.size() >= 6), 32'd1);
        for (int i = 0; i < 6; i++)
            check($sformatf("drain_%0d", i), got[i], mem_word(32'(i * 4)));

        // Redirect while the request for 0x8 is outstanding.
        do_reset();
        out_ready = 1'b1;
        tick();
        tick();
        tick();
        hold_resp      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        #1;
        check("redir_no_req", 32'(imem_req_valid), 32'd0);
        tick();
        redirect_valid = 1'b0;
        #1;
        check("redir_flush", 32'(out_valid), 32'd0);
        check("drop_no_req", 32'(imem_req_valid), 32'd0);
        hold_resp = 1'b0;
        #1;
        check("drop_resp_no_req", 32'(imem_req_valid), 32'd0);
        tick();
        check("redir_req_valid", 32'(imem_req_valid), 32'd1);
        check("redir_req_addr", imem_req_addr, 32'h100);
        tick();
        tick();
        check("redir_head", out_instr.instruction, mem_word(32'h100));
        tick();
        check("redir_got_size", 32'(got.size()), 32'd2);
        check("redir_got1", got[1], mem_word(32'h100));

        // Redirect in the same cycle as a response and a pop.
        do_reset();
        out_ready = 1'b1;
        tick();
        tick();
        check("pre_redir_out_valid", 32'(out_valid), 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        redirect_tag   = '0;
        tick();
        redirect_valid = 1'b0;
        #1;
        check("rsp_redir_out_valid", 32'(out_valid), 32'd0);
        check("rsp_redir_req_valid", 32'(imem_req_valid), 32'd1);
        check("rsp_redir_pc", imem_req_addr, 32'h200);
        check("rsp_redir_got", 32'(got.size()), 32'd0);
        tick();
        tick();
        check("beq_instr", out_instr.instruction, 32'h1040_0002);
        check("beq_tag", 32'(out_instr.branch_tag), 32'd0);
        tick();
        check("addiu_instr", out_instr.instruction, 32'h2401_0001);
        check("addiu_tag", 32'(out_instr.branch_tag), EXP_TAG_AFTER_BEQ);

        // Tag wrap: resume at the maximum tag, then a BEQ bumps it to 0.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        redirect_tag   = '1;
        tick();
        redirect_valid = 1'b0;
        redirect_tag   = '0;
        #1;
        check("wrap_req_valid", 32'(imem_req_valid), 32'd1);
        check("wrap_req_addr", imem_req_addr, 32'h300);
        tick();
        tick();
        check("wrap_beq_instr", out_instr.instruction, 32'h1040_0003);
        check("wrap_beq_tag", 32'(out_instr.branch_tag), EXP_TAG_MAX);
        tick();
        check("wrap_next_instr", out_instr.instruction, mem_word(32'h304));
        check("wrap_next_tag", 32'(out_instr.branch_tag), 32'd0);

        // Reset in the middle of a stream with a full queue.
        do_reset();
        out_ready = 1'b0;
        repeat (8) tick();
        check("mid_full_out_valid", 32'(out_valid), 32'd1);
        check("mid_full_req_valid", 32'(imem_req_valid), 32'd0);
        check("mid_full_head", out_instr.instruction, mem_word(32'h0));
        rst = 1'b1;
        tick();
        check("rst_mid_out_valid", 32'(out_valid), 32'd0);
        check("rst_mid_req_valid", 32'(imem_req_valid), 32'd0);
        rst = 1'b0;
        #1;
        check("rst_mid_req_valid_after", 32'(imem_req_valid), 32'd1);
        check("rst_mid_req_addr", imem_req_addr, RV);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
